// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: mult/div FSM encoding,
// default unit latencies and the hardwired zero register index.
package pipe_pkg;

  typedef enum logic {
    MD_RUN  = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic int mdLatency(input logic isDiv, input int multLat, input int divLat);
    return isDiv ? divLat : multLat;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_occupancy.sv
// Mult/div occupancy tracker: HI/LO is busy for a fixed latency after a start,
// with a done pulse in the final busy cycle and a sticky overlap error.
module md_occupancy
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_i,
  input  logic md_is_div_i,
  output logic md_busy_o,
  output logic md_done_o,
  output logic md_err_o
);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             err_q;

  // done is registered one cycle early so it lines up with the cnt==0 busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        MD_RUN: begin
          done_q <= 1'b0;
          if (md_start_i) begin
            state_q <= MD_BUSY;
            cnt_q   <= CNT_W'(mdLatency(md_is_div_i, MULT_LAT, DIV_LAT) - 1);
          end
        end
        MD_BUSY: begin
          if (md_start_i) begin
            err_q <= 1'b1;
          end
          if (cnt_q == '0) begin
            state_q <= MD_RUN;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - CNT_W'(1);
            done_q <= (cnt_q == CNT_W'(1));
          end
        end
        default: begin
          state_q <= MD_RUN;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy_o = (state_q == MD_BUSY);
  assign md_done_o = done_q;
  assign md_err_o  = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, branch flush gating
// and a saturating stall-cycle performance counter.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 6,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_IFID,
  input  logic [4:0]        rt_IFID,
  input  logic              uses_rt_IFID,
  input  logic [4:0]        rt_IDEX,
  input  logic              MemRead_IDEX,
  input  logic              md_start_IDEX,
  input  logic              md_is_div,
  input  logic              md_use_IFID,
  input  logic              branch_taken,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              ctrl_bubble,
  output logic              IFID_flush,
  output logic              md_busy,
  output logic              md_done,
  output logic              md_err,
  output logic [PERF_W-1:0] stall_cnt
);

  logic              loadUse;
  logic              mdHazard;
  logic              stall;
  logic [PERF_W-1:0] stallCnt_q;
  logic [PERF_W-1:0] stallCnt_d;

  md_occupancy #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_occupancy (
    .clk        (clk),
    .rst        (rst),
    .md_start_i (md_start_IDEX),
    .md_is_div_i(md_is_div),
    .md_busy_o  (md_busy),
    .md_done_o  (md_done),
    .md_err_o   (md_err)
  );

  // Reset forces the pipeline enables open so the datapath flushes cleanly
  always_comb begin
    loadUse  = MemRead_IDEX && (rt_IDEX != REG_ZERO) &&
               ((rt_IDEX == rs_IFID) || (uses_rt_IFID && (rt_IDEX == rt_IFID)));
    mdHazard = md_busy && md_use_IFID;
    stall    = !rst && (loadUse || mdHazard);

    PCWrite     = !stall;
    IFIDWrite   = !stall;
    ctrl_bubble = stall;
    IFID_flush  = !rst && branch_taken && !stall;

    stallCnt_d = stallCnt_q;
    if (stall && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all continuously checked against an interval-based model.
module tb_hazard_ctrl;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;
  localparam int CNT_W    = 6;
  localparam int PERF_W   = 5;
  localparam int MAXC     = (1 << PERF_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [4:0]        rs_IFID = '0;
  logic [4:0]        rt_IFID = '0;
  logic [4:0]        rt_IDEX = '0;
  logic              uses_rt_IFID = 1'b0;
  logic              MemRead_IDEX = 1'b0;
  logic              md_start_IDEX = 1'b0;
  logic              md_is_div = 1'b0;
  logic              md_use_IFID = 1'b0;
  logic              branch_taken = 1'b0;
  logic              PCWrite, IFIDWrite, ctrl_bubble, IFID_flush;
  logic              md_busy, md_done, md_err;
  logic [PERF_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Model: an accepted start in cycle c occupies HI/LO for cycles c+1..c+lat
  int cyc     = 0;
  bit mActive = 1'b0;
  int mEnd    = 0;
  bit mErr    = 1'b0;
  int mStall  = 0;
  bit checkEn = 1'b0;

  hazard_ctrl #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W),
    .PERF_W  (PERF_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rs_IFID      (rs_IFID),
    .rt_IFID      (rt_IFID),
    .uses_rt_IFID (uses_rt_IFID),
    .rt_IDEX      (rt_IDEX),
    .MemRead_IDEX (MemRead_IDEX),
    .md_start_IDEX(md_start_IDEX),
    .md_is_div    (md_is_div),
    .md_use_IFID  (md_use_IFID),
    .branch_taken (branch_taken),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .ctrl_bubble  (ctrl_bubble),
    .IFID_flush   (IFID_flush),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .md_err       (md_err),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit hazardNow(input bit busy);
    bit lu;
    lu = MemRead_IDEX && (rt_IDEX != 5'd0) &&
         ((rt_IDEX == rs_IFID) || (uses_rt_IFID && (rt_IDEX == rt_IFID)));
    return lu || (busy && md_use_IFID);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input int rs, input int rt, input bit urt,
                               input int rtex, input bit mr, input bit ms, input bit dv,
                               input bit mu, input bit br);
    @(posedge clk);
    #1;
    rst           = r;
    rs_IFID       = 5'(rs);
    rt_IFID       = 5'(rt);
    uses_rt_IFID  = urt;
    rt_IDEX       = 5'(rtex);
    MemRead_IDEX  = mr;
    md_start_IDEX = ms;
    md_is_div     = dv;
    md_use_IFID   = mu;
    branch_taken  = br;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Model advances on every rising edge using the inputs held during that cycle
  initial begin
    forever begin : modelStep
      bit busyNow;
      @(posedge clk);
      if (rst) begin
        mActive = 1'b0;
        mErr    = 1'b0;
        mStall  = 0;
      end else begin
        busyNow = mActive && (cyc <= mEnd);
        if (hazardNow(busyNow) && (mStall < MAXC)) mStall++;
        if (md_start_IDEX) begin
          if (busyNow) begin
            mErr = 1'b1;
          end else begin
            mActive = 1'b1;
            mEnd    = cyc + (md_is_div ? DIV_LAT : MULT_LAT);
          end
        end
      end
      cyc++;
      checkEn = 1'b1;
    end
  end

  // Compare every output against the model mid-cycle
  initial begin
    forever begin : compareStep
      bit eBusy, eDone, eStall;
      @(negedge clk);
      if (checkEn) begin
        eBusy  = mActive && (cyc <= mEnd);
        eDone  = mActive && (cyc == mEnd);
        eStall = !rst && hazardNow(eBusy);
        checkOutput("PCWrite", int'(PCWrite), int'(!eStall));
        checkOutput("IFIDWrite", int'(IFIDWrite), int'(!eStall));
        checkOutput("ctrl_bubble", int'(ctrl_bubble), int'(eStall));
        checkOutput("IFID_flush", int'(IFID_flush), int'(!rst && branch_taken && !eStall));
        checkOutput("md_busy", int'(md_busy), int'(eBusy));
        checkOutput("md_done", int'(md_done), int'(eDone));
        checkOutput("md_err", int'(md_err), int'(mErr));
        checkOutput("stall_cnt", int'(stall_cnt), mStall);
      end
    end
  end

  initial begin
    doReset();
    idle();
    @(negedge clk);
    checkOutput("lit_reset_stall_cnt", int'(stall_cnt), 0);
    checkOutput("lit_reset_md_busy", int'(md_busy), 0);
    checkOutput("lit_reset_PCWrite", int'(PCWrite), 1);

    // load-use on rs, then the rt_IDEX==0 exemption
    applyStimulus(0, 8, 0, 0, 8, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_lu_PCWrite", int'(PCWrite), 0);
    checkOutput("lit_lu_bubble", int'(ctrl_bubble), 1);
    idle();
    @(negedge clk);
    checkOutput("lit_lu_stall_cnt", int'(stall_cnt), 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_lu_zero_PCWrite", int'(PCWrite), 1);

    // rt comparison only counts when the ID instruction reads rt
    applyStimulus(0, 3, 9, 0, 9, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_urt0_PCWrite", int'(PCWrite), 1);
    applyStimulus(0, 3, 9, 1, 9, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lit_urt1_IFIDWrite", int'(IFIDWrite), 0);

    // mult occupancy with a dependent instruction waiting in ID
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    for (int k = 1; k <= MULT_LAT; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      checkOutput("lit_mult_busy", int'(md_busy), 1);
      checkOutput("lit_mult_done", int'(md_done), (k == MULT_LAT) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("lit_mult_after_busy", int'(md_busy), 0);
    checkOutput("lit_mult_stall_cnt", int'(stall_cnt), 4);

    // div with an illegal overlapping start at busy cycle 5
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    for (int k = 1; k <= DIV_LAT; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, (k == 5), 1, 0, 0);
      @(negedge clk);
      if (k == 6) checkOutput("lit_div_err", int'(md_err), 1);
      if (k >= DIV_LAT - 1) checkOutput("lit_div_done", int'(md_done), (k == DIV_LAT) ? 1 : 0);
    end
    idle();
    @(negedge clk);
    checkOutput("lit_div_err_sticky", int'(md_err), 1);

    // a stall holds the branch; the flush happens on the next free cycle
    doReset();
    applyStimulus(0, 8, 0, 0, 8, 1, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("lit_br_stalled_flush", int'(IFID_flush), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("lit_br_flush", int'(IFID_flush), 1);

    // reset in busy cycle 2 of a div aborts it without a done pulse
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("lit_rst_PCWrite", int'(PCWrite), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("lit_rst_busy", int'(md_busy), 0);
    checkOutput("lit_rst_stall_cnt", int'(stall_cnt), 0);
    for (int k = 0; k < DIV_LAT + 3; k++) begin
      idle();
      @(negedge clk);
      checkOutput("lit_rst_no_done", int'(md_done), 0);
    end

    // saturation of the narrow performance counter
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    for (int k = 0; k < DIV_LAT; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 5, 0, 0, 5, 1, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    checkOutput("lit_sat_stall_cnt", int'(stall_cnt), MAXC);

    // randomized traffic, small register range to provoke matches
    doReset();
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom % 64) == 0, int'($urandom % 4), int'($urandom % 4),
                    bit'($urandom % 2), int'($urandom % 4), bit'($urandom % 2),
                    ($urandom % 8) == 0, ($urandom % 4) == 0, bit'($urandom % 2),
                    bit'($urandom % 2));
    end
    idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
